// File: rtl/udma_eth_frame_pkg.sv
// Shared register map, bit positions and launch-state encoding for the
// multi-channel uDMA Ethernet-frame configuration block.
package udma_eth_frame_pkg;

    localparam logic [1:0] REG_SADDR  = 2'd0;
    localparam logic [1:0] REG_SIZE   = 2'd1;
    localparam logic [1:0] REG_CFG    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CFG_CONT_BIT   = 0;
    localparam int CFG_QUEUED_BIT = 3;
    localparam int CFG_EN_BIT     = 4;
    localparam int CFG_CLR_BIT    = 6;

    localparam int ST_DONE_BIT  = 0;
    localparam int ST_OVF_BIT   = 1;
    localparam int ST_IRQEN_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RUN_Q = 2'd2
    } launch_state_e;

endpackage

// File: rtl/udma_eth_frame_ch_ctrl.sv
// One channel: staging/queue/active registers, sticky status and the
// IDLE/RUN/RUN_Q launch state machine.
module udma_eth_frame_ch_ctrl
    import udma_eth_frame_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_i,
    input  logic [1:0]                reg_i,
    input  logic [31:0]               wdata_i,
    input  logic                      en_i,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr_o,
    output logic [TRANS_SIZE-1:0]     size_o,
    output logic                      continuous_o,
    output logic                      en_o,
    output logic                      clr_o,
    output logic                      irq_o,
    output logic                      queued_o,
    output logic                      cont_stg_o,
    output logic                      done_o,
    output logic                      ovf_o,
    output logic                      irq_en_o
);

    launch_state_e             state_q;
    logic [L2_AWIDTH_NOAL-1:0] saddr_stg_q, saddr_qd_q, saddr_act_q;
    logic [TRANS_SIZE-1:0]     size_stg_q, size_qd_q, size_act_q;
    logic                      cont_stg_q, cont_qd_q, cont_act_q;
    logic                      en_q, clr_q, inflight_q, en_prev_q;
    logic                      done_q, ovf_q, irq_en_q, irq_q;

    logic wr_saddr, wr_size, wr_cfg, wr_st, en_req, clr_req, busy, cont_new;
    logic done_d, ovf_d, irq_en_d;
    logic unused_wdata;

    assign wr_saddr = wr_i && (reg_i == REG_SADDR);
    assign wr_size  = wr_i && (reg_i == REG_SIZE);
    assign wr_cfg   = wr_i && (reg_i == REG_CFG);
    assign wr_st    = wr_i && (reg_i == REG_STATUS);
    // A clear in the same write as an enable suppresses the enable.
    assign clr_req  = wr_cfg && wdata_i[CFG_CLR_BIT];
    assign en_req   = wr_cfg && wdata_i[CFG_EN_BIT] && !wdata_i[CFG_CLR_BIT];
    assign cont_new = wr_cfg ? wdata_i[CFG_CONT_BIT] : cont_stg_q;
    assign busy     = en_i | inflight_q;

    // Set has priority over write-1-to-clear.
    assign done_d   = (done_q & ~(wr_st & wdata_i[ST_DONE_BIT])) | (en_prev_q & ~en_i);
    assign ovf_d    = (ovf_q & ~(wr_st & wdata_i[ST_OVF_BIT])) | (en_req && state_q == ST_RUN_Q);
    assign irq_en_d = wr_st ? wdata_i[ST_IRQEN_BIT] : irq_en_q;
    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            saddr_stg_q <= '0;
            saddr_qd_q  <= '0;
            saddr_act_q <= '0;
            size_stg_q  <= '0;
            size_qd_q   <= '0;
            size_act_q  <= '0;
            cont_stg_q  <= 1'b0;
            cont_qd_q   <= 1'b0;
            cont_act_q  <= 1'b0;
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
            inflight_q  <= 1'b0;
            en_prev_q   <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            en_q      <= 1'b0;
            clr_q     <= clr_req;
            en_prev_q <= en_i;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= done_d & irq_en_d;
            if (wr_saddr) saddr_stg_q <= wdata_i[L2_AWIDTH_NOAL-1:0];
            if (wr_size)  size_stg_q  <= wdata_i[TRANS_SIZE-1:0];
            if (wr_cfg)   cont_stg_q  <= wdata_i[CFG_CONT_BIT];
            if (en_i)     inflight_q  <= 1'b0;

            if (clr_req) begin
                state_q    <= ST_IDLE;
                inflight_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (en_req) begin
                        saddr_act_q <= saddr_stg_q;
                        size_act_q  <= size_stg_q;
                        cont_act_q  <= cont_new;
                        en_q        <= 1'b1;
                        inflight_q  <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                    ST_RUN: if (en_req) begin
                        saddr_qd_q <= saddr_stg_q;
                        size_qd_q  <= size_stg_q;
                        cont_qd_q  <= cont_new;
                        state_q    <= ST_RUN_Q;
                    end else if (!busy) begin
                        state_q <= ST_IDLE;
                    end
                    ST_RUN_Q: if (!busy) begin
                        saddr_act_q <= saddr_qd_q;
                        size_act_q  <= size_qd_q;
                        cont_act_q  <= cont_qd_q;
                        en_q        <= 1'b1;
                        inflight_q  <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign startaddr_o  = saddr_act_q;
    assign size_o       = size_act_q;
    assign continuous_o = cont_act_q;
    assign en_o         = en_q;
    assign clr_o        = clr_q;
    assign irq_o        = irq_q;
    assign queued_o     = (state_q == ST_RUN_Q);
    assign cont_stg_o   = cont_stg_q;
    assign done_o       = done_q;
    assign ovf_o        = ovf_q;
    assign irq_en_o     = irq_en_q;

endmodule

// File: rtl/udma_eth_frame_cfg_mch.sv
// Multi-channel uDMA Ethernet-frame cfg register file: address decode,
// read mux and one ch_ctrl instance per channel.
module udma_eth_frame_cfg_mch
    import udma_eth_frame_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int N_CH           = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic [31:0]                          cfg_data_i,
    input  logic [4:0]                           cfg_addr_i,
    input  logic                                 cfg_valid_i,
    input  logic                                 cfg_rwn_i,
    output logic [31:0]                          cfg_data_o,
    output logic                                 cfg_ready_o,
    output logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_startaddr_o,
    output logic [N_CH-1:0][TRANS_SIZE-1:0]      cfg_size_o,
    output logic [N_CH-1:0]                      cfg_continuous_o,
    output logic [N_CH-1:0]                      cfg_en_o,
    output logic [N_CH-1:0]                      cfg_clr_o,
    input  logic [N_CH-1:0]                      cfg_en_i,
    input  logic [N_CH-1:0]                      cfg_pending_i,
    input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]  cfg_curr_addr_i,
    input  logic [N_CH-1:0][TRANS_SIZE-1:0]      cfg_bytes_left_i,
    output logic [N_CH-1:0]                      irq_o
);

    logic [2:0]      ch_sel;
    logic [1:0]      reg_sel;
    logic [N_CH-1:0] queued, cont_stg, done, ovf, irq_en;

    assign ch_sel      = cfg_addr_i[4:2];
    assign reg_sel     = cfg_addr_i[1:0];
    assign cfg_ready_o = 1'b1;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        udma_eth_frame_ch_ctrl #(
            .L2_AWIDTH_NOAL(L2_AWIDTH_NOAL),
            .TRANS_SIZE    (TRANS_SIZE)
        ) u_ch (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .wr_i        (cfg_valid_i && !cfg_rwn_i && (ch_sel == 3'(g))),
            .reg_i       (reg_sel),
            .wdata_i     (cfg_data_i),
            .en_i        (cfg_en_i[g]),
            .startaddr_o (cfg_startaddr_o[g]),
            .size_o      (cfg_size_o[g]),
            .continuous_o(cfg_continuous_o[g]),
            .en_o        (cfg_en_o[g]),
            .clr_o       (cfg_clr_o[g]),
            .irq_o       (irq_o[g]),
            .queued_o    (queued[g]),
            .cont_stg_o  (cont_stg[g]),
            .done_o      (done[g]),
            .ovf_o       (ovf[g]),
            .irq_en_o    (irq_en[g])
        );
    end

    // Unmatched channel indices fall through with the zero default.
    always_comb begin
        cfg_data_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_valid_i && cfg_rwn_i && (ch_sel == 3'(i))) begin
                case (reg_sel)
                    REG_SADDR:  cfg_data_o = 32'(cfg_curr_addr_i[i]);
                    REG_SIZE:   cfg_data_o = 32'(cfg_bytes_left_i[i]);
                    REG_CFG:    cfg_data_o = {26'h0, cfg_pending_i[i], cfg_en_i[i],
                                              queued[i], 2'b00, cont_stg[i]};
                    default:    cfg_data_o = {23'h0, irq_en[i], 6'h0, ovf[i], done[i]};
                endcase
            end
        end
    end

endmodule

// File: doc/udma_eth_frame_cfg_mch.md
# udma_eth_frame_cfg_mch

Multi-channel configuration and control register file for the uDMA Ethernet-frame peripheral. It serves N_CH uDMA channels (for example RX/TX pairs of several MACs) from one cfg bus. Compared with the single RX/TX register file, it adds:
- a one-deep per-channel launch queue, so software can pre-arm the next transfer while one is running;
- sticky done and overflow status with write-1-to-clear semantics;
- a per-channel level interrupt.

## Interface
Parameters:
- L2_AWIDTH_NOAL, 12: L2 address width of start/current address.
- TRANS_SIZE, 16: transfer-size width.
- N_CH, 2: number of channels, 1..8.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cfg_data_i  in  32  write data.
- cfg_addr_i  in  5  word address: [4:2] channel, [1:0] register.
- cfg_valid_i  in  1  access strobe.
- cfg_rwn_i  in  1  1 = read, 0 = write.
- cfg_data_o  out  32  read data, combinational.
- cfg_ready_o  out  1  tied 1.
- cfg_startaddr_o  out  N_CH×L2_AWIDTH_NOAL  active start address per channel.
- cfg_size_o  out  N_CH×TRANS_SIZE  active size per channel.
- cfg_continuous_o  out  N_CH  continuous mode per channel.
- cfg_en_o  out  N_CH  one-cycle launch pulse.
- cfg_clr_o  out  N_CH  one-cycle clear pulse.
- cfg_en_i  in  N_CH  channel running, from uDMA.
- cfg_pending_i  in  N_CH  uDMA pending flag.
- cfg_curr_addr_i  in  N_CH×L2_AWIDTH_NOAL  current address.
- cfg_bytes_left_i  in  N_CH×TRANS_SIZE  bytes remaining.
- irq_o  out  N_CH  level interrupt, done & irq_en.

## Operation
- Per-channel registers:
  - 0 SADDR: write sets staging address; read returns curr_addr.
  - 1 SIZE: write sets staging size; read returns bytes_left, zero-extended.
  - 2 CFG: write bit0 continuous, bit4 enable, bit6 clear. Read returns {26'h0, pending_i, en_i, queued, 2'b0, continuous}, so queued sits at bit3.
  - 3 STATUS: bit0 done, bit1 overflow, bit8 irq_en. Bits 0-1 are W1C; bit8 is read/write.
- Channel index ≥ N_CH: writes are ignored and reads return 0.
- Read and write decode only when cfg_valid_i is high; otherwise cfg_data_o = 0.
- busy = cfg_en_i | inflight.
  - inflight is set with each en pulse.
  - inflight clears on the first cycle cfg_en_i = 1 is sampled, or on clear.
- Per-channel launch state machine, states IDLE / RUN / RUN_Q:
  - IDLE:
    - CFG write with bit4 = 1 → copy staging to active outputs, pulse en, go to RUN.
  - RUN:
    - CFG write with bit4 = 1 → snapshot staging and continuous into queue regs, go to RUN_Q.
    - busy = 0 → IDLE.
  - RUN_Q:
    - busy = 0 → copy queue regs to active outputs, pulse en, go to RUN.
    - another enable write → dropped, overflow set, queue kept.
- Done is set on each sampled 1→0 transition of cfg_en_i. In continuous mode cfg_en_i stays high, so done never sets.
- CFG write with bit6 = 1:
  - pulses clr and drops any queued request;
  - returns the state machine to IDLE, with inflight cleared;
  - does not touch done, overflow or staging.
  - If bit6 and bit4 are set in the same write, the clear wins and no enable pulse is issued.
- CFG continuous bit (bit0) is written to staging; it reaches the outputs at launch.

## Timing
- Reset values:
  - all outputs 0 except cfg_ready_o = 1;
  - staging, queue, active and status registers 0;
  - state machine in IDLE.
- Enable write at cycle T on an idle channel: cfg_en_o pulses at T+1 and the active outputs change at T+1.
- Queued launch: if busy = 0 is first sampled at T, the en pulse and the new outputs appear at T+1.
- Enable write in the same cycle cfg_en_i falls: the channel is still RUN, so the request is queued and launches one cycle later.
- Done is set one cycle after cfg_en_i falls.
- W1C and set in the same cycle: set wins.
- irq_o is registered off done/irq_en with no extra latency beyond the register update.
- Reset mid-transfer: everything returns to reset values immediately and no en pulse is issued.

## Structure
- Package udma_eth_frame_pkg holds:
  - register offsets (REG_SADDR, REG_SIZE, REG_CFG, REG_STATUS);
  - CFG and STATUS bit positions;
  - the launch-state enum.
- Sub-module udma_eth_frame_ch_ctrl holds one channel's staging, queue, active and status registers plus its state machine. It is instantiated N_CH times in a generate loop. The top level holds address decode and the read mux.

## Test plan
- Reset, then read all registers → 0; STATUS 0; irq_o = 0; cfg_ready_o = 1.
- Channel 1: write SADDR=0x100, SIZE=64, CFG=0x10 → cfg_en_o[1] pulses one cycle later with startaddr 0x100 and size 64. Drop cfg_en_i[1] → done=1. With irq_en=1, irq_o[1]=1; W1C → 0.
- While channel 0 runs: write SADDR=0x200, CFG=0x10 → queued=1. Then write SADDR=0x300 → queue still holds 0x200. Drop cfg_en_i → pulse with 0x200 one cycle later.
- While channel 0 runs with a request queued: a second enable write → overflow=1 and the queue is unchanged.
- Queued channel plus CFG=0x40 → clr pulse, queued=0, state IDLE; no launch when cfg_en_i later falls.
- Enable write in the same cycle cfg_en_i falls → queued, then launched one cycle later. W1C of done in the same cycle as a new done → done stays 1.
